// File: rtl/traffic_test_sequencer.sv
// traffic_test_sequencer
// Runs one loopback test on a port as an AXI4-Lite master: selects the GMII
// mux path, enables the traffic generator for run_cycles, disables it, then
// reads the MAC 64-bit RX good-frame counter twice (drain_cycles apart) and
// produces a pass/fail verdict.
// Ports:
//   i_aclk, i_areset          clock, synchronous active-high reset
//   i_start                   one-cycle start pulse (honoured only in IDLE)
//   i_run_cycles/i_drain_cycles/i_min_frames  run parameters, sampled at start
//   o_m_axi_* / i_m_axi_*     AXI4-Lite master (AW, W, B, AR, R channels)
//   o_busy, o_done            activity flag, one-cycle end-of-run pulse
//   o_pass, o_err_code        verdict (0 ok,1 bus err,2 timeout,3 few frames,4 moving)
//   o_rx_frames               first counter snapshot
module traffic_test_sequencer #(
  parameter logic [31:0] MUX_ADDR = 32'hA0200000,
  parameter logic [31:0] TG_ADDR  = 32'hA0270000,
  parameter logic [31:0] MAC_ADDR = 32'hA0000000,
  parameter logic [31:0] MUX_SEL  = 32'h00000003,
  parameter int          CNT_W    = 32,
  parameter int          TIMEOUT  = 1024
) (
  input  logic             i_aclk,
  input  logic             i_areset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_run_cycles,
  input  logic [CNT_W-1:0] i_drain_cycles,
  input  logic [63:0]      i_min_frames,
  output logic [31:0]      o_m_axi_awaddr,
  output logic             o_m_axi_awvalid,
  input  logic             i_m_axi_awready,
  output logic [31:0]      o_m_axi_wdata,
  output logic [3:0]       o_m_axi_wstrb,
  output logic             o_m_axi_wvalid,
  input  logic             i_m_axi_wready,
  input  logic [1:0]       i_m_axi_bresp,
  input  logic             i_m_axi_bvalid,
  output logic             o_m_axi_bready,
  output logic [31:0]      o_m_axi_araddr,
  output logic             o_m_axi_arvalid,
  input  logic             i_m_axi_arready,
  input  logic [31:0]      i_m_axi_rdata,
  input  logic [1:0]       i_m_axi_rresp,
  input  logic             i_m_axi_rvalid,
  output logic             o_m_axi_rready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [2:0]       o_err_code,
  output logic [63:0]      o_rx_frames
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_MUX, WR_TG_EN, RUN, WR_TG_DIS, DRAIN1, RD1_LO, RD1_HI,
    DRAIN2, RD2_LO, RD2_HI, CHECK, DONE
  } state_t;

  state_t           r_state, w_next, w_succ;
  logic             r_aw_done, r_w_done, r_ar_done;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_wait_cnt, r_run_len, r_drain_len, w_wait_len;
  logic [63:0]      r_min_frames, r_rx_frames, r_snap2;
  logic             r_pass;
  logic [2:0]       r_err;
  logic             w_wr_st, w_rd_st, w_wait_st, w_b_hs, w_r_hs, w_xfer_done;
  logic             w_resp_err, w_timeout, w_wait_done, w_enter;

  always_comb begin
    w_next         = r_state;
    w_succ         = IDLE;
    o_m_axi_awaddr = '0;
    o_m_axi_wdata  = '0;
    o_m_axi_araddr = '0;
    w_wr_st   = (r_state == WR_MUX) || (r_state == WR_TG_EN) || (r_state == WR_TG_DIS);
    w_rd_st   = (r_state == RD1_LO) || (r_state == RD1_HI) ||
                (r_state == RD2_LO) || (r_state == RD2_HI);
    w_wait_st = (r_state == RUN) || (r_state == DRAIN1) || (r_state == DRAIN2);

    case (r_state)
      WR_MUX:    begin o_m_axi_awaddr = MUX_ADDR + 32'h8;  o_m_axi_wdata = MUX_SEL;  end
      WR_TG_EN:  begin o_m_axi_awaddr = TG_ADDR + 32'h10;  o_m_axi_wdata = 32'd1;    end
      WR_TG_DIS: begin o_m_axi_awaddr = TG_ADDR + 32'h10;  o_m_axi_wdata = 32'd0;    end
      RD1_LO, RD2_LO: o_m_axi_araddr = MAC_ADDR + 32'h290;
      RD1_HI, RD2_HI: o_m_axi_araddr = MAC_ADDR + 32'h294;
      default: ;
    endcase

    o_m_axi_wstrb   = 4'hF;
    o_m_axi_awvalid = w_wr_st & ~r_aw_done;
    o_m_axi_wvalid  = w_wr_st & ~r_w_done;
    o_m_axi_bready  = w_wr_st & r_aw_done & r_w_done;
    o_m_axi_arvalid = w_rd_st & ~r_ar_done;
    o_m_axi_rready  = w_rd_st & r_ar_done;

    w_b_hs      = i_m_axi_bvalid & o_m_axi_bready;
    w_r_hs      = i_m_axi_rvalid & o_m_axi_rready;
    w_xfer_done = w_b_hs | w_r_hs;
    w_resp_err  = (w_b_hs && i_m_axi_bresp != 2'b00) || (w_r_hs && i_m_axi_rresp != 2'b00);
    // Timeout fires in the TIMEOUT-th cycle of a bus state unless it completes then.
    w_timeout   = (w_wr_st | w_rd_st) & ~w_xfer_done & (r_to_cnt == TO_W'(TIMEOUT - 1));

    w_wait_len  = (r_state == RUN) ? r_run_len : r_drain_len;
    // A zero length still spends one cycle in the wait state.
    w_wait_done = (w_wait_len == '0) || (r_wait_cnt == w_wait_len - CNT_W'(1));

    case (r_state)
      IDLE:      w_succ = WR_MUX;
      WR_MUX:    w_succ = WR_TG_EN;
      WR_TG_EN:  w_succ = RUN;
      RUN:       w_succ = WR_TG_DIS;
      WR_TG_DIS: w_succ = DRAIN1;
      DRAIN1:    w_succ = RD1_LO;
      RD1_LO:    w_succ = RD1_HI;
      RD1_HI:    w_succ = DRAIN2;
      DRAIN2:    w_succ = RD2_LO;
      RD2_LO:    w_succ = RD2_HI;
      RD2_HI:    w_succ = CHECK;
      CHECK:     w_succ = DONE;
      default:   w_succ = IDLE;
    endcase

    if (w_wr_st || w_rd_st) begin
      if (w_resp_err || w_timeout) w_next = DONE;
      else if (w_xfer_done)        w_next = w_succ;
    end else if (w_wait_st) begin
      if (w_wait_done) w_next = w_succ;
    end else if (r_state == IDLE) begin
      if (i_start) w_next = w_succ;
    end else begin
      w_next = w_succ;
    end

    w_enter = (w_next != r_state);
    o_busy  = (r_state != IDLE) && (r_state != DONE);
    o_done  = (r_state == DONE);
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_aw_done <= 1'b0; r_w_done <= 1'b0; r_ar_done <= 1'b0;
      r_to_cnt <= '0; r_wait_cnt <= '0;
      r_run_len <= '0; r_drain_len <= '0; r_min_frames <= '0;
      r_rx_frames <= '0; r_snap2 <= '0; r_pass <= 1'b0; r_err <= 3'd0;
    end else begin
      if (o_m_axi_awvalid & i_m_axi_awready) r_aw_done <= 1'b1;
      if (o_m_axi_wvalid & i_m_axi_wready)   r_w_done  <= 1'b1;
      if (o_m_axi_arvalid & i_m_axi_arready) r_ar_done <= 1'b1;
      // Every state starts with fresh handshake flags and counters.
      if (w_enter) begin
        r_aw_done <= 1'b0; r_w_done <= 1'b0; r_ar_done <= 1'b0;
        r_to_cnt <= '0; r_wait_cnt <= '0;
      end else begin
        if (w_wr_st | w_rd_st) r_to_cnt   <= r_to_cnt + TO_W'(1);
        if (w_wait_st)         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end

      if (r_state == IDLE && i_start) begin
        r_run_len <= i_run_cycles; r_drain_len <= i_drain_cycles;
        r_min_frames <= i_min_frames;
        r_rx_frames <= '0; r_snap2 <= '0; r_pass <= 1'b0; r_err <= 3'd0;
      end

      if (w_resp_err)     r_err <= 3'd1;
      else if (w_timeout) r_err <= 3'd2;

      if (w_r_hs && i_m_axi_rresp == 2'b00) begin
        case (r_state)
          RD1_LO:  r_rx_frames[31:0]  <= i_m_axi_rdata;
          RD1_HI:  r_rx_frames[63:32] <= i_m_axi_rdata;
          RD2_LO:  r_snap2[31:0]      <= i_m_axi_rdata;
          RD2_HI:  r_snap2[63:32]     <= i_m_axi_rdata;
          default: ;
        endcase
      end

      if (r_state == CHECK) begin
        if (r_rx_frames < r_min_frames) r_err  <= 3'd3;
        else if (r_snap2 != r_rx_frames) r_err <= 3'd4;
        else                             r_pass <= 1'b1;
      end
    end
  end

  assign o_pass      = r_pass;
  assign o_err_code  = r_err;
  assign o_rx_frames = r_rx_frames;
endmodule

// File: tb/tb_traffic_test_sequencer.sv
// Bench for traffic_test_sequencer: AXI4-Lite slave model with programmable
// ready delays, error injection and a 64-bit counter model; expected writes
// and verdicts are queued at stimulus time and popped as the DUT produces them.
module tb_traffic_test_sequencer;
  localparam logic [31:0] MUX_A = 32'hA0200000, TG_A = 32'hA0270000, MAC_A = 32'hA0000000;
  localparam int TMO = 1024;

  logic        clk = 1'b0, areset = 1'b1, start = 1'b0;
  logic [31:0] run_cycles = '0, drain_cycles = '0;
  logic [63:0] min_frames = '0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        busy, done, pass;
  logic [2:0]  err_code;
  logic [63:0] rx_frames;

  traffic_test_sequencer dut (
    .i_aclk(clk), .i_areset(areset), .i_start(start),
    .i_run_cycles(run_cycles), .i_drain_cycles(drain_cycles), .i_min_frames(min_frames),
    .o_m_axi_awaddr(awaddr), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
    .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready),
    .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready),
    .o_m_axi_araddr(araddr), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
    .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_code(err_code), .o_rx_frames(rx_frames)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0;
  bit          en_berr = 0, ar_hang = 0;
  logic [63:0] cnt1 = '0, cnt2 = '0;
  int          aw_cnt = 0, w_cnt = 0, rd_n = 0;
  logic        aw_got = 0, w_got = 0;
  logic [31:0] s_awaddr = '0, s_wdata = '0;

  assign awready = awvalid && (aw_cnt + 1 >= aw_delay);
  assign wready  = wvalid  && (w_cnt + 1 >= w_delay);
  assign arready = arvalid && !ar_hang;
  assign rresp   = 2'b00;

  always @(posedge clk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 0; w_got <= 0; bvalid <= 0; bresp <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready)   ? w_cnt + 1  : 0;
      if (awvalid && awready) begin aw_got <= 1; s_awaddr <= awaddr; end
      if (wvalid && wready)   begin w_got  <= 1; s_wdata  <= wdata;  end
      if (bvalid && bready) bvalid <= 0;
      else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        bvalid <= 1; aw_got <= 0; w_got <= 0;
        bresp <= (en_berr && ((awvalid && awready) ? awaddr : s_awaddr) == TG_A + 32'h10 &&
                  ((wvalid && wready) ? wdata : s_wdata) == 32'd1) ? 2'b10 : 2'b00;
      end
    end
  end

  always @(posedge clk) begin
    if (areset) begin
      rvalid <= 0; rd_n <= 0; rdata <= '0;
    end else begin
      if (start) rd_n <= 0;
      else if (rvalid && rready) rd_n <= rd_n + 1;
      if (rvalid && rready) rvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1;
        if (araddr == MAC_A + 32'h294) rdata <= (rd_n < 2) ? cnt1[63:32] : cnt2[63:32];
        else                           rdata <= (rd_n < 2) ? cnt1[31:0]  : cnt2[31:0];
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic p; logic [2:0] e; logic [63:0] rx; } res_t;
  res_t        exp_res[$];
  logic [31:0] exp_aw[$], exp_wd[$];
  int          b_t[$], aw_rise[$], ar_rise[$], r_t[$];
  int          aw_hi_n = 0, w_hi_n = 0, ar_hi_n = 0, b_n = 0;
  logic        prev_aw = 0, prev_ar = 0;

  always @(negedge clk) begin
    if (!areset) begin
      if (awvalid) begin
        aw_hi_n++;
        if (exp_aw.size() == 0) chk("aw_unexpected", {32'd0, awaddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("awaddr", {32'd0, awaddr}, {32'd0, exp_aw[0]});
          if (awready) void'(exp_aw.pop_front());
        end
        if (!prev_aw) aw_rise.push_back(cyc);
      end
      if (wvalid) begin
        w_hi_n++;
        chk("wstrb", {60'd0, wstrb}, 64'hF);
        if (exp_wd.size() == 0) chk("w_unexpected", {32'd0, wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("wdata", {32'd0, wdata}, {32'd0, exp_wd[0]});
          if (wready) void'(exp_wd.pop_front());
        end
      end
      if (bvalid && bready) begin b_t.push_back(cyc); b_n++; end
      if (arvalid) begin ar_hi_n++; if (!prev_ar) ar_rise.push_back(cyc); end
      if (rvalid && rready) r_t.push_back(cyc);
    end
    prev_aw = awvalid && !areset;
    prev_ar = arvalid && !areset;
  end

  task automatic clear_mon();
    b_t.delete(); aw_rise.delete(); ar_rise.delete(); r_t.delete();
    aw_hi_n = 0; w_hi_n = 0; ar_hi_n = 0; b_n = 0;
  endtask

  // Waits (bounded) for the done pulse; returns at the negedge where done is high.
  task automatic wait_done(input int bound);
    bit   got = 0;
    res_t r;
    for (int i = 0; i < bound; i++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", bound);
    end else if (exp_res.size() == 0) begin
      chk("done_unexpected", 64'd1, 64'd0);
    end else begin
      r = exp_res.pop_front();
      chk("pass", {63'd0, pass}, {63'd0, r.p});
      chk("err_code", {61'd0, err_code}, {61'd0, r.e});
      chk("rx_frames", rx_frames, r.rx);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic run_vec(input int run, input int drain, input logic [63:0] minf,
                         input logic [63:0] c1, input logic [63:0] c2,
                         input logic ep, input logic [2:0] ee, input logic [63:0] erx,
                         input int nwr, input bit timing, input int poke, input bit poke_done);
    logic [31:0] wa[3] = '{MUX_A + 32'h8, TG_A + 32'h10, TG_A + 32'h10};
    logic [31:0] wd[3] = '{32'h3, 32'h1, 32'h0};
    int   er, ed, aw_snap;
    res_t r;
    clear_mon();
    for (int i = 0; i < nwr; i++) begin exp_aw.push_back(wa[i]); exp_wd.push_back(wd[i]); end
    r.p = ep; r.e = ee; r.rx = erx;
    exp_res.push_back(r);
    cnt1 = c1; cnt2 = c2;
    run_cycles = run; drain_cycles = drain; min_frames = minf;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("pass_cleared", {63'd0, pass}, 64'd0);
    chk("err_cleared", {61'd0, err_code}, 64'd0);
    chk("rx_cleared", rx_frames, 64'd0);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(4000);
    if (poke_done) start = 1;   // lands on the DONE cycle's edge
    @(negedge clk);
    start = 0;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("pass_held", {63'd0, pass}, {63'd0, ep});
    chk("err_held", {61'd0, err_code}, {61'd0, ee});
    if (poke_done) begin
      aw_snap = aw_hi_n;
      repeat (4) @(negedge clk);
      chk("no_start_on_done_busy", {63'd0, busy}, 64'd0);
      chk("no_start_on_done_aw", aw_hi_n, aw_snap);
    end
    chk("writes_consumed", exp_aw.size(), 0);
    if (timing) begin
      er = (run == 0) ? 1 : run;
      ed = (drain == 0) ? 1 : drain;
      if (b_t.size() == 3 && aw_rise.size() == 3 && ar_rise.size() == 4 && r_t.size() == 4) begin
        // the wait state occupies er (or ed) cycles between the two bus events
        chk("run_len", aw_rise[2] - b_t[1], er + 1);
        chk("drain1_len", ar_rise[0] - b_t[2], ed + 1);
        chk("drain2_len", ar_rise[2] - r_t[1], ed + 1);
      end else begin
        chk("bus_event_count", b_t.size() * 1000 + ar_rise.size(), 3004);
      end
    end
  endtask

  typedef struct {
    int run, drain; logic [63:0] minf, c1, c2; logic ep; logic [2:0] ee; logic [63:0] erx;
  } vec_t;
  vec_t vt[9];

  initial begin
    int snap_aw, snap_ar;
    vt[0] = '{100, 10, 64'd2, 64'd5, 64'd5, 1'b1, 3'd0, 64'd5};
    vt[1] = '{100, 10, 64'd2, 64'd1, 64'd1, 1'b0, 3'd3, 64'd1};
    vt[2] = '{100, 10, 64'd2, 64'd5, 64'd6, 1'b0, 3'd4, 64'd5};
    vt[3] = '{0,   0,  64'd2, 64'd5, 64'd5, 1'b1, 3'd0, 64'd5};
    vt[4] = '{3,   2,  64'h2_0000_0000, 64'h1_FFFF_FFFF, 64'h1_FFFF_FFFF, 1'b0, 3'd3, 64'h1_FFFF_FFFF};
    vt[5] = '{1,   1,  64'h1_0000_0000, 64'h1_0000_0005, 64'h1_0000_0005, 1'b1, 3'd0, 64'h1_0000_0005};
    vt[6] = '{2,   3,  64'd10, 64'd4, 64'd9, 1'b0, 3'd3, 64'd4};
    vt[7] = '{5,   5,  64'd0,  64'd0, 64'd0, 1'b1, 3'd0, 64'd0};
    vt[8] = '{4,   4,  64'd1,  64'd7, 64'h1_0000_0007, 1'b0, 3'd4, 64'd7};

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 0);   chk("rst_done", {63'd0, done}, 0);
    chk("rst_pass", {63'd0, pass}, 0);   chk("rst_err", {61'd0, err_code}, 0);
    chk("rst_rx", rx_frames, 0);
    chk("rst_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 0);
    areset = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_vec(vt[i].run, vt[i].drain, vt[i].minf, vt[i].c1, vt[i].c2,
              vt[i].ep, vt[i].ee, vt[i].erx, 3, 1, 0, 0);

    // AW held off 7 cycles, W accepted at once
    aw_delay = 7; w_delay = 0;
    run_vec(2, 2, 64'd1, 64'd3, 64'd3, 1'b1, 3'd0, 64'd3, 3, 0, 0, 0);
    chk("aw_valid_cycles", aw_hi_n, 21);
    chk("w_valid_cycles", w_hi_n, 3);
    chk("b_handshakes", b_n, 3);
    aw_delay = 0;

    // error response on the enable write: nothing further is written
    en_berr = 1;
    run_vec(5, 2, 64'd1, 64'd3, 64'd3, 1'b0, 3'd1, 64'd0, 2, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("berr_b_count", b_n, 2);
    chk("berr_ar_count", ar_hi_n, 0);
    en_berr = 0;

    // first read never accepted
    ar_hang = 1;
    run_vec(3, 2, 64'd1, 64'd3, 64'd3, 1'b0, 3'd2, 64'd0, 3, 0, 0, 0);
    chk("timeout_cycles", ar_hi_n, TMO);
    ar_hang = 0;

    // restart attempts while busy and on the DONE cycle are ignored
    run_vec(100, 10, 64'd2, 64'd5, 64'd5, 1'b1, 3'd0, 64'd5, 3, 1, 50, 1);

    // reset in the middle of a stalled address phase
    aw_delay = 50;
    clear_mon();
    exp_aw.push_back(MUX_A + 32'h8); exp_wd.push_back(32'h3);
    start = 1; @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    chk("mid_awvalid", {63'd0, awvalid}, 1);
    areset = 1;
    @(negedge clk);
    areset = 0;
    chk("rst_mid_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_mid_busy", {63'd0, busy}, 0);
    exp_aw.delete(); exp_wd.delete();
    snap_aw = aw_hi_n; snap_ar = ar_hi_n;
    repeat (20) @(negedge clk);
    chk("rst_mid_quiet_aw", aw_hi_n, snap_aw);
    chk("rst_mid_quiet_ar", ar_hi_n, snap_ar);
    chk("rst_mid_idle", {63'd0, busy}, 0);
    aw_delay = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/traffic_test_sequencer.md
Name: traffic_test_sequencer

Overview:
- Hardware sequencer for one loopback test run on a port: configures the GMII mux, enables and disables the traffic generator, and reads the MAC 64-bit RX good-frame statistics counter twice.
- Gives a pass/fail verdict without processor involvement.
- Acts as an AXI4-Lite master, arbitrated into the PS-side interconnect alongside the PS master; one instance per port.

Parameters:
- MUX_ADDR, 32'hA0200000, gmii_mux base; config reg at +8.
- TG_ADDR, 32'hA0270000, traffic generator base; control reg at +16, bit0 = enable.
- MAC_ADDR, 32'hA0000000, MAC base; RX good frames low word at +0x290, high word at +0x294.
- MUX_SEL, 32'h00000003, value written to the mux config reg.
- CNT_W, 32, width of run/drain cycle counters.
- TIMEOUT, 1024, maximum cycles waiting for any AXI handshake.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- run_cycles  in  CNT_W  generator-enabled duration, sampled at start
- drain_cycles  in  CNT_W  wait after disable and between counter reads, sampled at start
- min_frames  in  64  minimum RX frames required, sampled at start
- m_axi_awaddr/awvalid/awready  out/out/in  32/1/1  write address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel; wstrb always 4'hF
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
- m_axi_araddr/arvalid/arready  out/out/in  32/1/1  read address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle pulse at end of run
- pass  out  1  verdict, held until next start
- err_code  out  3  0 ok, 1 bus error, 2 timeout, 3 too few frames, 4 counter still moving
- rx_frames  out  64  first counter snapshot

Behaviour:
- Reset: all outputs 0; all valid/ready lows; state IDLE; counters cleared. Reset mid-transaction abandons it immediately; no further bus activity.
- States, in order:
  - IDLE -> WR_MUX on start.
  - WR_MUX -> WR_TG_EN -> RUN -> WR_TG_DIS -> DRAIN1 -> RD1_LO -> RD1_HI -> DRAIN2 -> RD2_LO -> RD2_HI -> CHECK -> DONE -> IDLE.
  - WR_TG_EN writes 1; WR_TG_DIS writes 0.
- Write sub-sequence:
  - awvalid and wvalid assert together on state entry.
  - Each channel drops independently the cycle after its valid&ready.
  - bready is high once both address and data are accepted; completes on bvalid&bready.
  - Payload is stable while valid is high.
- Read sub-sequence:
  - arvalid asserts on state entry and drops after arready.
  - rready then asserts; rdata is captured on rvalid&rready.
- Resp != 0 on bresp or rresp -> err_code=1, go to DONE. No further writes; the generator may be left enabled (intended, for debug).
- Timeout: a per-transaction counter resets at each state entry. Reaching TIMEOUT cycles without completion -> err_code=2, DONE.
- Wait states:
  - RUN lasts exactly run_cycles cycles, then the disable write is issued.
  - DRAIN1 and DRAIN2 last exactly drain_cycles cycles.
  - A value of 0 means a 1-cycle pass-through.
- CHECK, 1 cycle:
  - snapshot1 < min_frames -> code 3.
  - else snapshot2 != snapshot1 -> code 4.
  - else pass=1, code 0.
  - Code 3 takes priority over 4.
- Counter snapshots: snapshot1 loads rx_frames (low word then high word); snapshot2 goes to an internal register. Compare is unsigned 64-bit.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- start while busy is ignored. start coincident with the DONE cycle is ignored.
- pass, err_code and rx_frames hold until the next accepted start, which clears them.

Test Plan:
- Zero-latency AXI slave model; run_cycles=100, drain_cycles=10, min_frames=2; counter model returns 5 both times:
  - AW/W sequence is MUX_ADDR+8=3, TG_ADDR+16=1, TG_ADDR+16=0.
  - Disable write is issued exactly 100 cycles after enable completes.
  - pass=1, rx_frames=5, err_code=0.
- Counter returns 1 -> pass=0, err_code=3. Counter returns 5 then 6 -> err_code=4.
- Slave delays awready by 7 cycles and wready by 0 -> single B handshake; wvalid drops after 1 cycle while awvalid holds 7; data stable.
- bresp=2'b10 on the enable write -> err_code=2'd1 path (code 1), no further AW transactions, done pulses.
- arready never asserted on RD1_LO -> err_code=2 after exactly TIMEOUT cycles; areset pulsed mid-write -> all valids low the next cycle, busy=0.
- start pulsed while busy -> no restart.
- run_cycles=0, drain_cycles=0 -> full sequence completes; each wait state lasts 1 cycle.
